bramreadsum: RTL and testbench

//  Reader counterpart of the generated BRAM-writer kernels: owns a DualPortRAM field "a_0".

---
 rtl/bramreadsum_pkg.sv | 19 +
 rtl/bramreadsum_if.sv | 25 ++
 rtl/bramreadsum_dpram.sv | 46 ++++
 rtl/bramreadsum.sv | 145 ++++++++++++++
 tb/tb_bramreadsum.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/bramreadsum_pkg.sv
// rtl/bramreadsum_pkg.sv - method/phase encodings shared with the BRAM writer kernels
package bramreadsum_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 2;
    localparam int WORDS_DEF  = 4;

    typedef enum logic [1:0] {
        METHOD_IDLE = 2'h0,
        METHOD_RUN  = 2'h1
    } method_e;

    typedef enum logic [2:0] {
        PHASE_INIT = 3'h0,
        PHASE_READ = 3'h2,
        PHASE_DONE = 3'h4
    } phase_e;

endpackage

// File: rtl/bramreadsum_if.sv
// rtl/bramreadsum_if.sv - run handshake, results and field a_0 port-0 bundle
interface bramreadsum_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 2
);
    logic              ce;
    logic              i_run_req;
    logic              o_run_busy;
    logic [DWIDTH-1:0] o_run_return_sum;
    logic [DWIDTH-1:0] o_run_return_max;
    logic [AWIDTH-1:0] i_fld_a_0_addr_0;
    logic [DWIDTH-1:0] i_fld_a_0_datain_0;
    logic [DWIDTH-1:0] o_fld_a_0_dataout_0;
    logic              i_fld_a_0_r_w_0;

    modport master (
        output ce, i_run_req, i_fld_a_0_addr_0, i_fld_a_0_datain_0, i_fld_a_0_r_w_0,
        input  o_run_busy, o_run_return_sum, o_run_return_max, o_fld_a_0_dataout_0
    );

    modport slave (
        input  ce, i_run_req, i_fld_a_0_addr_0, i_fld_a_0_datain_0, i_fld_a_0_r_w_0,
        output o_run_busy, o_run_return_sum, o_run_return_max, o_fld_a_0_dataout_0
    );
endinterface

// File: rtl/bramreadsum_dpram.sv
// rtl/bramreadsum_dpram.sv - true dual-port RAM, registered outputs, read-first on both ports
module bramreadsum_dpram #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 2,
    parameter int WORDS  = 4
) (
    input  logic              clock,
    input  logic              ce_0,
    input  logic [AWIDTH-1:0] addr_0,
    input  logic [DWIDTH-1:0] datain_0,
    input  logic              r_w_0,
    output logic [DWIDTH-1:0] dataout_0,
    input  logic              ce_1,
    input  logic [AWIDTH-1:0] addr_1,
    input  logic [DWIDTH-1:0] datain_1,
    input  logic              r_w_1,
    output logic [DWIDTH-1:0] dataout_1
);
    logic [DWIDTH-1:0] mem [WORDS];

    // Reads return the pre-write contents, so a same-cycle write on either port is
    // seen by a read of that word only on the following access.
    always_ff @(posedge clock) begin
        if (ce_0) begin
            if (int'(addr_0) < WORDS) begin
                dataout_0 <= mem[addr_0];
                if (r_w_0) begin
                    mem[addr_0] <= datain_0;
                end
            end else begin
                dataout_0 <= '0;
            end
        end
        if (ce_1) begin
            if (int'(addr_1) < WORDS) begin
                dataout_1 <= mem[addr_1];
                if (r_w_1) begin
                    mem[addr_1] <= datain_1;
                end
            end else begin
                dataout_1 <= '0;
            end
        end
    end

endmodule

// File: rtl/bramreadsum.sv
// rtl/bramreadsum.sv - reads field a_0 back on run request, returns signed sum and max
module bramreadsum
    import bramreadsum_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic          clock,
    input  logic          reset,
    bramreadsum_if.slave  bus
);
    localparam int SW = ((AWIDTH + 1) > $clog2(WORDS + 2)) ? (AWIDTH + 1) : $clog2(WORDS + 2);
    localparam logic [SW-1:0]     STEP_WORDS = SW'(WORDS);
    localparam logic [SW-1:0]     STEP_LAST  = SW'(WORDS + 1);
    localparam logic [SW-1:0]     STEP_FIRST = SW'(2);
    localparam logic [DWIDTH-1:0] MOST_NEG   = {1'b1, {(DWIDTH - 1){1'b0}}};

    method_e           method_q, method_d;
    phase_e            phase_q, phase_d;
    logic [SW-1:0]     step_q, step_d;
    logic              busy_q, busy_d;
    logic [DWIDTH-1:0] acc_sum_q, acc_sum_d;
    logic [DWIDTH-1:0] acc_max_q, acc_max_d;
    logic [DWIDTH-1:0] ret_sum_q, ret_sum_d;
    logic [DWIDTH-1:0] ret_max_q, ret_max_d;
    logic [AWIDTH-1:0] addr1_q, addr1_d;
    logic [DWIDTH-1:0] dataout_1;

    bramreadsum_dpram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WORDS  (WORDS)
    ) dpram_a_0 (
        .clock     (clock),
        .ce_0      (bus.ce),
        .addr_0    (bus.i_fld_a_0_addr_0),
        .datain_0  (bus.i_fld_a_0_datain_0),
        .r_w_0     (bus.i_fld_a_0_r_w_0),
        .dataout_0 (bus.o_fld_a_0_dataout_0),
        .ce_1      (bus.ce),
        .addr_1    (addr1_q),
        .datain_1  ('0),
        .r_w_1     (1'b0),
        .dataout_1 (dataout_1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            method_q  <= METHOD_IDLE;
            phase_q   <= PHASE_INIT;
            step_q    <= '0;
            busy_q    <= 1'b0;
            acc_sum_q <= '0;
            acc_max_q <= '0;
            ret_sum_q <= '0;
            ret_max_q <= '0;
            addr1_q   <= '0;
        end else if (bus.ce) begin
            method_q  <= method_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            acc_sum_q <= acc_sum_d;
            acc_max_q <= acc_max_d;
            ret_sum_q <= ret_sum_d;
            ret_max_q <= ret_max_d;
            addr1_q   <= addr1_d;
        end
    end

    always_comb begin
        method_d  = method_q;
        phase_d   = phase_q;
        step_d    = step_q;
        busy_d    = busy_q;
        acc_sum_d = acc_sum_q;
        acc_max_d = acc_max_q;
        ret_sum_d = ret_sum_q;
        ret_max_d = ret_max_q;
        addr1_d   = addr1_q;
        unique case (method_q)
            METHOD_IDLE: begin
                busy_d = bus.i_run_req;
                if (bus.i_run_req) begin
                    method_d = METHOD_RUN;
                    phase_d  = PHASE_INIT;
                end
            end
            METHOD_RUN: begin
                unique case (phase_q)
                    PHASE_INIT: begin
                        busy_d    = 1'b1;
                        acc_sum_d = '0;
                        acc_max_d = MOST_NEG;
                        step_d    = '0;
                        phase_d   = PHASE_READ;
                    end
                    PHASE_READ: begin
                        if (step_q < STEP_WORDS) begin
                            addr1_d = step_q[AWIDTH-1:0];
                        end
                        // Address registered then RAM output registered: word k lands at step k+2.
                        if (step_q >= STEP_FIRST) begin
                            acc_sum_d = acc_sum_q + dataout_1;
                            if ($signed(dataout_1) > $signed(acc_max_q)) begin
                                acc_max_d = dataout_1;
                            end
                        end
                        if (step_q == STEP_LAST) begin
                            phase_d = PHASE_DONE;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                    PHASE_DONE: begin
                        ret_sum_d = acc_sum_q;
                        ret_max_d = acc_max_q;
                        busy_d    = 1'b0;
                        phase_d   = PHASE_INIT;
                        method_d  = METHOD_IDLE;
                    end
                    default: begin
                        busy_d   = 1'b0;
                        phase_d  = PHASE_INIT;
                        method_d = METHOD_IDLE;
                    end
                endcase
            end
            default: begin
                busy_d   = 1'b0;
                phase_d  = PHASE_INIT;
                method_d = METHOD_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.o_run_busy       = busy_q;
        bus.o_run_return_sum = ret_sum_q;
        bus.o_run_return_max = ret_max_q;
    end

endmodule

// File: tb/tb_bramreadsum.sv
// tb/tb_bramreadsum.sv - directed self-checking bench with result scoreboard
module tb_bramreadsum;

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] max;
    } exp_t;

    logic clock;
    logic reset;
    int   vectors;
    int   errors;
    int   cnt;
    exp_t sb[$];

    bramreadsum_if #(.DWIDTH(32), .AWIDTH(2)) bus ();

    bramreadsum #(
        .DWIDTH (32),
        .AWIDTH (2),
        .WORDS  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.i_fld_a_0_addr_0   = a;
        bus.i_fld_a_0_datain_0 = d;
        bus.i_fld_a_0_r_w_0    = 1'b1;
        step();
        bus.i_fld_a_0_r_w_0    = 1'b0;
    endtask

    task automatic wr4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
        wr(2'd0, w0);
        wr(2'd1, w1);
        wr(2'd2, w2);
        wr(2'd3, w3);
    endtask

    // Counts busy cycles from the current one; optionally drops ce for 3 cycles.
    task automatic wait_done(input int stall_at, output int n);
        n = 0;
        while (bus.o_run_busy === 1'b1 && n < 200) begin
            n++;
            if (n == stall_at) bus.ce = 1'b0;
            if (n == stall_at + 3) bus.ce = 1'b1;
            step();
        end
        bus.ce = 1'b1;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected queued result", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, bus.o_run_return_sum, e.sum);
            chk({tag, "_max"}, bus.o_run_return_max, e.max);
        end
    endtask

    task automatic run(input string tag, input int stall_at, input int exp_len);
        int n;
        bus.i_run_req = 1'b1;
        step();
        bus.i_run_req = 1'b0;
        wait_done(stall_at, n);
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
        check_result(tag);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.ce  = 1'b1;
        bus.i_run_req          = 1'b0;
        bus.i_fld_a_0_addr_0   = '0;
        bus.i_fld_a_0_datain_0 = '0;
        bus.i_fld_a_0_r_w_0    = 1'b0;
        repeat (2) step();
        chk("rst_busy", 32'(bus.o_run_busy), 32'd0);
        chk("rst_sum", bus.o_run_return_sum, 32'd0);
        chk("rst_max", bus.o_run_return_max, 32'd0);
        reset = 1'b0;
        step();

        wr4(32'd1, 32'd2, 32'd3, 32'd4);
        bus.i_fld_a_0_addr_0 = 2'd1;
        step();
        chk("port0_rd", bus.o_fld_a_0_dataout_0, 32'd2);

        sb.push_back('{sum: 32'd10, max: 32'd4});
        run("t1", 0, 8);

        sb.push_back('{sum: 32'd10, max: 32'd4});
        run("t4_stall", 3, 11);

        wr4(32'h7FFF_FFFF, 32'd1, -32'sd5, -32'sd1);
        sb.push_back('{sum: 32'h7FFF_FFFA, max: 32'h7FFF_FFFF});
        run("t2_wrap", 0, 8);

        wr4(-32'sd3, -32'sd3, -32'sd3, -32'sd3);
        sb.push_back('{sum: 32'hFFFF_FFF4, max: 32'hFFFF_FFFD});
        run("t3_neg", 0, 8);

        // Abort at READ step 2, then confirm a clean rerun.
        bus.i_run_req = 1'b1;
        step();
        bus.i_run_req = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy", 32'(bus.o_run_busy), 32'd0);
        chk("t5_sum", bus.o_run_return_sum, 32'd0);
        chk("t5_max", bus.o_run_return_max, 32'd0);
        step();
        sb.push_back('{sum: 32'hFFFF_FFF4, max: 32'hFFFF_FFFD});
        run("t5_rerun", 0, 8);

        wr4(32'd1, 32'd2, 32'd3, 32'd4);
        sb.push_back('{sum: 32'd10, max: 32'd4});
        sb.push_back('{sum: 32'd18, max: 32'd9});
        bus.i_run_req = 1'b1;
        step();
        wait_done(0, cnt);
        chk("t6_len1", 32'(cnt), 32'd8);
        check_result("t6_run1");
        chk("t6_gap", 32'(bus.o_run_busy), 32'd0);
        bus.i_fld_a_0_addr_0   = 2'd0;
        bus.i_fld_a_0_datain_0 = 32'd9;
        bus.i_fld_a_0_r_w_0    = 1'b1;
        step();
        bus.i_fld_a_0_r_w_0    = 1'b0;
        bus.i_run_req          = 1'b0;
        chk("t6_restart", 32'(bus.o_run_busy), 32'd1);
        wait_done(0, cnt);
        chk("t6_len2", 32'(cnt), 32'd8);
        check_result("t6_run2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
